// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared register-bus constants and load-type codes for the writeback stage
package wb_stage_pkg;
  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;

  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  typedef enum logic [2:0] {
    LOAD_W  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_BU = 3'd2,
    LOAD_H  = 3'd3,
    LOAD_HU = 3'd4
  } load_type_e;
endpackage

// File: rtl/wb_late_fifo.sv
// rtl/wb_late_fifo.sv - synchronous FIFO holding late-unit results until the regfile port is free
import wb_stage_pkg::*;

module wb_late_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_tvalid,
  output logic             push_tready,
  input  logic [WIDTH-1:0] push_tdata,
  input  logic             pop,
  output logic             head_tvalid,
  output logic [WIDTH-1:0] head_tdata,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Readiness comes from the registered count only, so a full FIFO refuses
  // a push even in a cycle where it also pops.
  assign push_tready = (rst != RST_ENABLE) && (count < CNT_W'(DEPTH));
  assign head_tvalid = (count != '0);
  assign head_tdata  = mem[rd_ptr];
  assign do_push     = push_tvalid && push_tready;
  assign do_pop      = pop && head_tvalid;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tdata;
  end
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: slot register, load alignment, and regfile port arbitration
import wb_stage_pkg::*;

module wb_stage #(
  parameter int DATA_W     = REG_BUS,
  parameter int ADDR_W     = REG_ADDR_BUS,
  parameter int LATE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wreg_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              mem_load_i,
  input  logic [2:0]        mem_load_type_i,
  input  logic [1:0]        mem_byte_off_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              late_valid_i,
  output logic              late_ready_o,
  input  logic [ADDR_W-1:0] late_waddr_i,
  input  logic [DATA_W-1:0] late_wdata_i,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic              stall_req_o
);
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(LATE_DEPTH + 1);

  logic              slot_valid, slot_done;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] load_data, mem_result;
  logic              slot_write, fifo_pop, fifo_nonempty;
  logic [ENTRY_W-1:0] head_tdata;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  fifo_count;

  always_comb begin
    ld_byte = mem_rdata_i[7:0];
    case (mem_byte_off_i)
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      2'd3:    ld_byte = mem_rdata_i[31:24];
      default: ld_byte = mem_rdata_i[7:0];
    endcase
    // Halfword loads ignore offset[0]; misaligned accesses never reach this stage.
    ld_half   = mem_byte_off_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    load_data = mem_rdata_i;
    case (load_type_e'(mem_load_type_i))
      LOAD_B:  load_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LOAD_BU: load_data = {{(DATA_W-8){1'b0}}, ld_byte};
      LOAD_H:  load_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      LOAD_HU: load_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: load_data = mem_rdata_i;
    endcase
    mem_result = mem_load_i ? load_data : mem_wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      slot_valid <= 1'b0;
      slot_done  <= 1'b0;
      slot_addr  <= '0;
      slot_data  <= DATA_W'(ZERO_WORD);
    end else if (flush_i) begin
      slot_valid <= 1'b0;
      slot_done  <= 1'b0;
    end else if (stall_i) begin
      // A held instruction writes once, then yields the port to the FIFO.
      slot_done  <= slot_done || slot_write;
    end else begin
      slot_valid <= mem_wreg_i && (mem_waddr_i != '0);
      slot_done  <= 1'b0;
      slot_addr  <= mem_waddr_i;
      slot_data  <= mem_result;
    end
  end

  wb_late_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LATE_DEPTH),
    .CNT_W (CNT_W)
  ) u_late_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_tvalid (late_valid_i),
    .push_tready (late_ready_o),
    .push_tdata  ({late_waddr_i, late_wdata_i}),
    .pop         (fifo_pop),
    .head_tvalid (fifo_nonempty),
    .head_tdata  (head_tdata),
    .count       (fifo_count)
  );

  assign {head_addr, head_data} = head_tdata;
  assign slot_write = slot_valid && !slot_done;
  assign fifo_pop   = !slot_write && fifo_nonempty;

  // Entries addressed to $0 are drained through the port without a write.
  always_comb begin
    wb_we_o    = 1'b0;
    wb_waddr_o = '0;
    wb_wdata_o = DATA_W'(ZERO_WORD);
    if (slot_write) begin
      wb_we_o    = WRITE_ENABLE;
      wb_waddr_o = slot_addr;
      wb_wdata_o = slot_data;
    end else if (fifo_pop) begin
      wb_we_o    = (head_addr != '0);
      wb_waddr_o = head_addr;
      wb_wdata_o = head_data;
    end
  end

  assign stall_req_o = (fifo_count == CNT_W'(LATE_DEPTH));
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage against a queue-based reference model
module tb_wb_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_wreg_i = 1'b0;
  logic [4:0]  mem_waddr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic        mem_load_i = 1'b0;
  logic [2:0]  mem_load_type_i = '0;
  logic [1:0]  mem_byte_off_i = '0;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        late_valid_i = 1'b1;
  logic        late_ready_o;
  logic [4:0]  late_waddr_i = '0;
  logic [31:0] late_wdata_i = '0;
  logic        wb_we_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic        stall_req_o;

  int n_vec  = 0;
  int n_fail = 0;
  int n4     = 0;
  bit cnt4_en = 0;

  wb_stage #(.DATA_W(32), .ADDR_W(5), .LATE_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_wreg_i      (mem_wreg_i),
    .mem_waddr_i     (mem_waddr_i),
    .mem_wdata_i     (mem_wdata_i),
    .mem_load_i      (mem_load_i),
    .mem_load_type_i (mem_load_type_i),
    .mem_byte_off_i  (mem_byte_off_i),
    .mem_rdata_i     (mem_rdata_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .late_valid_i    (late_valid_i),
    .late_ready_o    (late_ready_o),
    .late_waddr_i    (late_waddr_i),
    .late_wdata_i    (late_wdata_i),
    .wb_we_o         (wb_we_o),
    .wb_waddr_o      (wb_waddr_o),
    .wb_wdata_o      (wb_wdata_o),
    .stall_req_o     (stall_req_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending pipeline write plus an ordered list of late results.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } late_t;

  late_t       q[$];
  bit          m_live = 0;
  bit          m_valid = 0;
  bit          m_written = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  function automatic logic [31:0] model_align(input logic [31:0] w, input logic [2:0] ty,
                                              input logic [1:0] off);
    logic [31:0] v;
    case (ty)
      3'd1, 3'd2: begin
        v = (w >> (8 * int'(off))) & 32'hFF;
        if (ty == 3'd1 && v >= 32'd128) v = v - 32'd256;
      end
      3'd3, 3'd4: begin
        v = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
        if (ty == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    bit    owns;
    bit    take;
    late_t e;
    if (rst) begin
      m_live    = 1;
      m_valid   = 0;
      m_written = 0;
      q.delete();
    end else if (m_live) begin
      owns = m_valid && !m_written;
      take = late_valid_i && (q.size() < DEPTH);
      if (!owns && q.size() > 0) void'(q.pop_front());
      if (take) begin
        e.a = late_waddr_i;
        e.d = late_wdata_i;
        q.push_back(e);
      end
      if (flush_i) m_valid = 0;
      else if (stall_i) begin
        if (owns) m_written = 1;
      end else begin
        m_valid   = mem_wreg_i && (mem_waddr_i != 5'd0);
        m_addr    = mem_waddr_i;
        m_data    = mem_load_i ? model_align(mem_rdata_i, mem_load_type_i, mem_byte_off_i)
                               : mem_wdata_i;
        m_written = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit          e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    if (m_live) begin
      e_we = 0;
      e_a  = '0;
      e_d  = '0;
      if (m_valid && !m_written) begin
        e_we = 1;
        e_a  = m_addr;
        e_d  = m_data;
      end else if (q.size() > 0) begin
        e_we = (q[0].a != 5'd0);
        e_a  = q[0].a;
        e_d  = q[0].d;
      end
      check("model_we", 32'(wb_we_o), 32'(e_we));
      if (e_we) begin
        check("model_waddr", 32'(wb_waddr_o), 32'(e_a));
        check("model_wdata", wb_wdata_o, e_d);
      end
      check("model_ready", 32'(late_ready_o), 32'(!rst && q.size() < DEPTH));
      check("model_stall_req", 32'(stall_req_o), 32'(q.size() == DEPTH));
    end
    if (cnt4_en && wb_we_o && wb_waddr_o == 5'd4) n4++;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic load_case(input string name, input logic [2:0] ty, input logic [1:0] off,
                           input logic [31:0] exp);
    mem_wreg_i      = 1'b1;
    mem_waddr_i     = 5'd7;
    mem_load_i      = 1'b1;
    mem_rdata_i     = 32'h8001_7FFF;
    mem_load_type_i = ty;
    mem_byte_off_i  = off;
    next();
    check({name, "_we"}, 32'(wb_we_o), 32'd1);
    check(name, wb_wdata_o, exp);
  endtask

  initial begin
    // Reset held two cycles with a late result on offer.
    next();
    check("rst_ready", 32'(late_ready_o), 32'd0);
    check("rst_we", 32'(wb_we_o), 32'd0);
    next();
    check("rst_ready2", 32'(late_ready_o), 32'd0);
    rst = 1'b0;
    late_valid_i = 1'b0;
    next();
    check("post_rst_ready", 32'(late_ready_o), 32'd1);
    check("post_rst_stall", 32'(stall_req_o), 32'd0);

    mem_wreg_i = 1'b1; mem_waddr_i = 5'd5; mem_wdata_i = 32'h1234_5678;
    next();
    check("alu_we", 32'(wb_we_o), 32'd1);
    check("alu_addr", 32'(wb_waddr_o), 32'd5);
    check("alu_data", wb_wdata_o, 32'h1234_5678);
    mem_waddr_i = 5'd0;
    next();
    check("x0_we", 32'(wb_we_o), 32'd0);

    load_case("lb_off3", 3'd1, 2'd3, 32'hFFFF_FF80);
    load_case("lbu_off3", 3'd2, 2'd3, 32'h0000_0080);
    load_case("lh_off2", 3'd3, 2'd2, 32'hFFFF_8001);
    load_case("lhu_off0", 3'd4, 2'd0, 32'h0000_7FFF);
    load_case("lb_off1", 3'd1, 2'd1, 32'h0000_007F);
    load_case("lw", 3'd0, 2'd2, 32'h8001_7FFF);
    mem_load_i = 1'b0;

    // Three pipeline writes while two late results queue up behind them.
    mem_waddr_i = 5'd1; mem_wdata_i = 32'h1;
    late_valid_i = 1'b1; late_waddr_i = 5'd9; late_wdata_i = 32'hA;
    next();
    mem_waddr_i = 5'd2; mem_wdata_i = 32'h2;
    late_waddr_i = 5'd10; late_wdata_i = 32'hB;
    next();
    check("full_stall_req", 32'(stall_req_o), 32'd1);
    check("full_ready", 32'(late_ready_o), 32'd0);
    late_valid_i = 1'b0;
    mem_waddr_i = 5'd3; mem_wdata_i = 32'h3;
    next();
    check("arb_slot_addr", 32'(wb_waddr_o), 32'd3);
    mem_wreg_i = 1'b0;
    next();
    check("late9_we", 32'(wb_we_o), 32'd1);
    check("late9_addr", 32'(wb_waddr_o), 32'd9);
    check("late9_data", wb_wdata_o, 32'hA);
    next();
    check("late10_addr", 32'(wb_waddr_o), 32'd10);
    check("late10_data", wb_wdata_o, 32'hB);
    next();
    check("drained_we", 32'(wb_we_o), 32'd0);
    check("drained_ready", 32'(late_ready_o), 32'd1);

    // Write-once: addr 4 held three stall cycles with one FIFO entry waiting.
    mem_wreg_i = 1'b1; mem_waddr_i = 5'd4; mem_wdata_i = 32'h44;
    late_valid_i = 1'b1; late_waddr_i = 5'd12; late_wdata_i = 32'hC;
    next();
    cnt4_en = 1;
    check("hold4_addr", 32'(wb_waddr_o), 32'd4);
    stall_i = 1'b1; late_valid_i = 1'b0;
    mem_waddr_i = 5'd6; mem_wdata_i = 32'h66;
    next();
    check("hold_fifo_we", 32'(wb_we_o), 32'd1);
    check("hold_fifo_addr", 32'(wb_waddr_o), 32'd12);
    check("hold_fifo_data", wb_wdata_o, 32'hC);
    next();
    check("hold_idle_we", 32'(wb_we_o), 32'd0);
    stall_i = 1'b0; mem_wreg_i = 1'b0;
    next();
    cnt4_en = 0;
    check("addr4_write_count", 32'(n4), 32'd1);

    // A flushed MEM instruction never writes; flush beats a concurrent stall.
    mem_wreg_i = 1'b1; mem_waddr_i = 5'd8; mem_wdata_i = 32'h88; flush_i = 1'b1;
    next();
    check("flush_we", 32'(wb_we_o), 32'd0);
    flush_i = 1'b0; mem_waddr_i = 5'd11; mem_wdata_i = 32'hBB;
    next();
    check("pre_flush_addr", 32'(wb_waddr_o), 32'd11);
    stall_i = 1'b1; flush_i = 1'b1; mem_wreg_i = 1'b0;
    next();
    check("flush_stall_we", 32'(wb_we_o), 32'd0);
    stall_i = 1'b0; flush_i = 1'b0;

    // A late result addressed to $0 drains without a write.
    late_valid_i = 1'b1; late_waddr_i = 5'd0; late_wdata_i = 32'h55;
    next();
    late_valid_i = 1'b0;
    check("x0_late_we", 32'(wb_we_o), 32'd0);
    next();
    check("x0_late_ready", 32'(late_ready_o), 32'd1);

    // Reset while two late results are queued.
    mem_wreg_i = 1'b1; mem_waddr_i = 5'd1; mem_wdata_i = 32'h1;
    late_valid_i = 1'b1; late_waddr_i = 5'd13; late_wdata_i = 32'hD;
    next();
    mem_waddr_i = 5'd2; late_waddr_i = 5'd14; late_wdata_i = 32'hE;
    next();
    check("pre_rst_full", 32'(stall_req_o), 32'd1);
    rst = 1'b1; late_valid_i = 1'b0; mem_wreg_i = 1'b0;
    next();
    check("midrst_we", 32'(wb_we_o), 32'd0);
    check("midrst_stall_req", 32'(stall_req_o), 32'd0);
    rst = 1'b0;
    next();
    check("after_rst_we", 32'(wb_we_o), 32'd0);
    check("after_rst_ready", 32'(late_ready_o), 32'd1);
    next();
    check("after_rst_we2", 32'(wb_we_o), 32'd0);
    next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage pipeline and the sole driver of the register file's write port (`write_enable`, `write_addr`, `write_data`). It registers the MEM-stage result, aligns and extends load data, and merges out-of-order results from long-latency units (divider, multiplier) through a small FIFO. Writeback is arbitrated so that exactly one register write is issued per cycle. When the FIFO is full, the block requests a pipeline stall.

## Interface
Parameters:
- `DATA_W`, 32, register data width (`RegBus`)
- `ADDR_W`, 5, register address width (`RegAddrBus`)
- `LATE_DEPTH`, 2, late-result FIFO entries (power of two)

Ports:
- `clk`  in  1  the single clock; everything is on its rising edge
- `rst`  in  1  reset, synchronous, active-high (`RstEnable` = 1)
- `mem_wreg_i`  in  1  MEM stage wants a register write
- `mem_waddr_i`  in  ADDR_W  destination register
- `mem_wdata_i`  in  DATA_W  ALU/forwarded result (non-load)
- `mem_load_i`  in  1  instruction is a load; use aligned `mem_rdata_i`
- `mem_load_type_i`  in  3  load kind: LW/LB/LBU/LH/LHU
- `mem_byte_off_i`  in  2  address bits [1:0]
- `mem_rdata_i`  in  DATA_W  raw word from data memory
- `stall_i`  in  1  ctrl stall; WB register holds
- `flush_i`  in  1  ctrl flush; WB register becomes a bubble
- `late_valid_i`  in  1  late unit offers a result
- `late_ready_o`  out  1  FIFO accepts this cycle
- `late_waddr_i`  in  ADDR_W  late destination
- `late_wdata_i`  in  DATA_W  late data
- `wb_we_o`  out  1  regfile write enable
- `wb_waddr_o`  out  ADDR_W  regfile write address
- `wb_wdata_o`  out  DATA_W  regfile write data
- `stall_req_o`  out  1  FIFO full; asks ctrl to stall

## Operation
- **WB slot register.** Fields: valid, addr, data, done.
  - Priority: `rst` > `flush_i` > `stall_i` > capture.
  - Flush clears valid.
  - Stall holds all fields.
  - Capture loads `valid = mem_wreg_i && mem_waddr_i != 0` and `done = 0`.
- **Load alignment** is combinational before capture. Little-endian: offset 0 selects bits [7:0].
  - LW: whole word.
  - LB/LBU: byte selected by the offset, sign- or zero-extended.
  - LH/LHU: halfword selected by offset[1]; offset[0] ignored (misalignment is trapped upstream).
- **Port arbitration** each cycle:
  1. The slot writes if valid and not done.
  2. Otherwise the FIFO head is popped and written.
  3. Otherwise `wb_we_o = 0`.
- **Write-once rule.** A slot write issued while `stall_i = 1` sets done, so a held instruction writes exactly once. This frees the port so the FIFO can drain and cannot deadlock against `stall_req_o`.
- **FIFO flow control.**
  - `late_ready_o = !rst && count < LATE_DEPTH`, evaluated on the registered count.
  - Push happens on `late_valid_i && late_ready_o`. Push and pop in the same cycle are allowed; count is unchanged.
  - When full, no push is accepted even if a pop occurs that cycle.
  - Entries with addr 0 are accepted but popped without a write (`wb_we_o = 0` for that pop).
- **Ordering.** FIFO order is preserved. Register ordering between late and pipeline results is guaranteed by the upstream scoreboard and is not checked here.
- **Stall request.** `stall_req_o = (count == LATE_DEPTH)`.

## Timing
- Reset values: `wb_we_o = 0`, `wb_waddr_o = 0`, `wb_wdata_o = 0`, `late_ready_o = 0`, `stall_req_o = 0`; FIFO empty; slot invalid.
- Reset mid-operation discards the slot and all FIFO entries, with no write issued.
- MEM to regfile latency is 1 cycle. The `wb_*` outputs are combinational from the slot and FIFO registers only, never from inputs.
- Late result: written no earlier than the cycle after its handshake; delayed for as long as the slot owns the port.
- A flush in the same cycle as a stall clears the slot.

## Structure
- **Shared package** (`macro.v`):
  - Load-type codes: LW=0, LB=1, LBU=2, LH=3, LHU=4.
  - Constants already used there: `RegBus`, `RegAddrBus`, `WriteEnable`, `RstEnable`, `ZeroWord`.
- **Sub-module** `wb_late_fifo`: a synchronous FIFO with valid/ready push, pop, head, and count.
- **Stays in `wb_stage`:** alignment and arbitration.

## Test plan
- **Reset.** Hold `rst` for 2 cycles with `late_valid_i = 1`.
  - During reset: `late_ready_o = 0`, `wb_we_o = 0`.
  - Cycle after release: `late_ready_o = 1`.
- **ALU write and $0.**
  - `mem_wreg_i = 1`, addr 5, data 0x12345678 → next cycle `wb_we_o = 1`, addr 5, data 0x12345678.
  - addr 0 → `wb_we_o = 0`.
- **Loads**, `mem_rdata_i = 0x80017FFF`:
  - LB off 3 → 0xFFFFFF80.
  - LBU off 3 → 0x00000080.
  - LH off 2 → 0xFFFF8001.
  - LHU off 0 → 0x00007FFF.
- **Arbitration and FIFO full.** Pipeline writes 3 consecutive cycles; late pushes addr 9/0xA then addr 10/0xB.
  - After the second push: `stall_req_o = 1` and `late_ready_o = 0`.
  - Addr 9 is written in the first idle cycle, addr 10 in the next.
- **Write-once under stall.** Slot holds addr 4 with `stall_i = 1` for 3 cycles, FIFO holds 1 entry.
  - `wb_we_o` for addr 4 asserts exactly once.
  - The FIFO entry is written in the following cycle.
- **Flush and mid-operation reset.**
  - `flush_i` with a valid slot → no write.
  - `rst` with 2 FIFO entries → entries dropped; after release, count is 0 and no writes occur.
